// File: rtl/planet_trail_buffer.sv
// Trail memory for one body: captures its position every SAMPLE_DIV frames into a DEPTH-entry ring
// and reports per pixel (one-clock latency) whether the beam is on a stored dot. Optional macro: TRAIL_FADE_EN (age output).
module planet_trail_buffer #(
    parameter int DEPTH      = 8,
    parameter int SAMPLE_DIV = 4,
    parameter int DOT_SHIFT  = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          enable,
    input  logic          clear,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    input  logic          display_on,
    output logic          trail_hit,
    output logic [AW-1:0] trail_age,
    output logic [AW:0]   fill_count
);

    logic [DEPTH-1:0] ent_valid;
    logic [9:0]       ent_x [DEPTH];
    logic [9:0]       ent_y [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [3:0]       div_cnt;
    logic [DEPTH-1:0] match;
    logic             any_match;
    logic             capture;
    logic             off_screen;

    assign capture    = frame_tick && enable && (div_cnt == 4'(SAMPLE_DIV - 1));
    // Negative positions still consume a slot so the dots keep even time spacing.
    assign off_screen = pos_x[9] || pos_y[9];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid  <= '0;
            wr_ptr     <= '0;
            div_cnt    <= '0;
            fill_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_x[i] <= '0;
                ent_y[i] <= '0;
            end
        end else if (clear) begin
            ent_valid  <= '0;
            wr_ptr     <= '0;
            div_cnt    <= '0;
            fill_count <= '0;
        end else if (frame_tick && enable) begin
            if (capture) begin
                div_cnt           <= '0;
                ent_valid[wr_ptr] <= !off_screen;
                ent_x[wr_ptr]     <= pos_x;
                ent_y[wr_ptr]     <= pos_y;
                wr_ptr            <= wr_ptr + 1'b1;
                if (fill_count != (AW+1)'(DEPTH))
                    fill_count <= fill_count + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ent_valid[i]
                    && ((pix_x >> DOT_SHIFT) == (ent_x[i] >> DOT_SHIFT))
                    && ((pix_y >> DOT_SHIFT) == (ent_y[i] >> DOT_SHIFT));
        end
    end

    assign any_match = |match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trail_hit <= 1'b0;
        else
            trail_hit <= display_on && any_match;
    end

`ifdef TRAIL_FADE_EN
    logic [AW-1:0] min_age;
    logic [AW-1:0] age_i;
    logic          found;

    // Age counts back from the most recent write slot, wrapping modulo DEPTH.
    always_comb begin
        min_age = '0;
        found   = 1'b0;
        age_i   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_i = wr_ptr - AW'(1) - AW'(i);
            if (match[i] && (!found || age_i < min_age)) begin
                min_age = age_i;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trail_age <= '0;
        else
            trail_age <= (display_on && any_match) ? min_age : '0;
    end
`else
    assign trail_age = '0;
`endif

endmodule

// File: doc/planet_trail_buffer.md
# planet_trail_buffer

Per-body trail memory for the three-body VGA display. Once every `SAMPLE_DIV` frames it captures one body's current position into a `DEPTH`-entry ring buffer. Every pixel it reports whether the beam lies on a stored trail dot, and how old that dot is. It sits downstream of the once-per-frame physics update, consuming body X/Y. It shares the pixel counters from the sync generator, and feeds the colour mux that composites trails beneath the planet disks.

## Interface

Parameters:
- `DEPTH`, 8: ring-buffer entries; power of two, 2..16.
- `SAMPLE_DIV`, 4: frames between captures, 1..15.
- `DOT_SHIFT`, 2: coordinate quantisation; a dot is a 2^DOT_SHIFT square.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: reset, asynchronous and active-high.
- `frame_tick` in 1: one-cycle pulse at pixel (0,0).
- `enable` in 1: capture enable; sampled only on `frame_tick`.
- `clear` in 1: synchronous buffer clear.
- `pos_x` in 10: body X, signed two's complement.
- `pos_y` in 10: body Y, signed two's complement.
- `pix_x` in 10: current beam X, unsigned.
- `pix_y` in 10: current beam Y, unsigned.
- `display_on` in 1: beam inside the visible area.
- `trail_hit` out 1: registered; beam is on a valid trail dot.
- `trail_age` out log2(DEPTH): registered; age of the youngest matching entry (0 = newest).
- `fill_count` out log2(DEPTH)+1: number of valid entries, 0..DEPTH.

## Operation

- **State:** `DEPTH` entries, each holding {valid, x[9:0], y[9:0]}, plus:
  - `wr_ptr`, log2(DEPTH) bits;
  - `div_cnt`, 4 bits;
  - `fill_count`.
- **Divider:** on `frame_tick` with `enable`=1:
  - if `div_cnt` == SAMPLE_DIV-1, issue a capture and set `div_cnt` to 0;
  - otherwise increment `div_cnt`.
- **Divider hold:** `frame_tick` with `enable`=0 leaves `div_cnt` and the buffer unchanged.
- **Capture:** entry[`wr_ptr`] <= {valid, `pos_x`, `pos_y`}, then `wr_ptr` increments.
  - `wr_ptr` wraps from DEPTH-1 to 0, overwriting the oldest entry.
  - `fill_count` increments and saturates at DEPTH.
- **Off-screen capture:** if `pos_x`[9] or `pos_y`[9] is set (negative), the entry is written with valid=0.
  - `wr_ptr` and `fill_count` still advance, so the trail keeps its time spacing.
- **Clear:** clears all valid bits and sets `wr_ptr`, `div_cnt` and `fill_count` to 0.
  - `clear` overrides a coincident capture; nothing is written that cycle.
- **Match:** entry i matches when valid_i is set and:
  - `pix_x`>>DOT_SHIFT == x_i>>DOT_SHIFT (logical shift; the valid entry is non-negative);
  - the same holds for y.
- **Age:** age_i = (`wr_ptr` - 1 - i) mod DEPTH.
  - `trail_age` takes the minimum age_i over all matching entries.
- **Outputs:** `trail_hit` <= `display_on` & |match.
  - `trail_age` <= that minimum when hit, else 0.

## Timing

- **Reset:** all outputs and internal state are 0; all entries are invalid.
- **Pixel path latency:** one clock. The outputs in cycle n+1 reflect `pix_x`/`pix_y`/`display_on` from cycle n.
  - The consumer delays its planet colour and syncs by one cycle to align.
- **Capture visibility:** a capture on the `frame_tick` cycle takes effect at the next edge.
  - The pixel evaluated in the tick cycle itself uses the pre-capture contents.
- **Positions:** `pos_x`/`pos_y` are sampled on the capture edge only and must be stable in that cycle. The physics block updates them on the same tick, so the captured value is the pre-update position.
- **Reset mid-frame:** asynchronous; outputs drop to 0 immediately.
  - The first capture after reset happens on the SAMPLE_DIV-th enabled tick.
- **Throughput:** at most one capture per frame, one pixel evaluated per clock.

## Configuration

- **`TRAIL_FADE_EN` defined:** the age/min-age logic is built and `trail_age` is driven as specified.
- **`TRAIL_FADE_EN` undefined:**
  - `trail_age` is tied to 0 and the age comparators are removed;
  - `trail_hit`, `fill_count` and capture behaviour are unchanged.

## Test plan

- **Fill and saturate:** reset, `enable`=1, SAMPLE_DIV=4, `pos`=(100,50); after 4 ticks `fill_count`=1 and `wr_ptr`=1. After 4·DEPTH+8 ticks `fill_count`=8 (saturated).
- **Hit/miss:** entry (100,50), DOT_SHIFT=2:
  - pixel (102,49) gives `trail_hit`=1 one cycle later, `trail_age`=0;
  - pixel (104,50) gives `trail_hit`=0;
  - same pixel with `display_on`=0 gives `trail_hit`=0.
- **Wrap and age:** capture 9 distinct positions with DEPTH=8:
  - first position no longer hits;
  - 9th hits with age 0;
  - 2nd hits with age 7.
- **Overlap:** positions equal in 3 consecutive captures; `trail_age` reports the youngest (0).
- **Off-screen and enable:** `pos_x`=-5 capture gives no hit anywhere but `fill_count` increments. `enable`=0 over 10 ticks leaves `div_cnt`/`fill_count` unchanged.
- **Clear and reset:** `clear` coincident with a capture tick:
  - `fill_count`=0, no entry written;
  - async `reset` pulse mid-line forces `trail_hit`=0 before the next clock edge.
